// File: rtl/simple_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : simple_pkg
//  Description : Shared constants and types for the SIMPLE 5-stage pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package simple_pkg;

    localparam int SIMPLE_DATA_W     = 16;
    localparam int SIMPLE_REG_ADDR_W = 3;
    localparam int SIMPLE_NUM_REGS   = 8;

    typedef logic [15:0] word_t;
    typedef logic [2:0]  reg_addr_t;

endpackage
`default_nettype wire

// File: rtl/p5_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module      : p5_writeback_if
//  Description : Memory-stage, decode read-port and forwarding signals of the
//                writeback stage. master = surrounding pipeline, slave = WB.
//  Revision    : 1.0 - initial release
// ============================================================================
interface p5_writeback_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
);
    logic              writeRegIn;
    logic [ADDR_W-1:0] regAddressIn;
    logic              readOutSelect;
    logic [DATA_W-1:0] aluOutData;
    logic [DATA_W-1:0] readOutData;
    logic [ADDR_W-1:0] rsAddr;
    logic [ADDR_W-1:0] rtAddr;
    logic [DATA_W-1:0] rsData;
    logic [DATA_W-1:0] rtData;
    logic [DATA_W-1:0] wbData;
    logic              wbWrite;
    logic [ADDR_W-1:0] wbAddress;
    logic              prevWrite;
    logic [ADDR_W-1:0] prevAddress;
    logic [DATA_W-1:0] prevData;
    logic [CNT_W-1:0]  retireCount;

    modport master (
        output writeRegIn, regAddressIn, readOutSelect, aluOutData, readOutData,
        output rsAddr, rtAddr,
        input  rsData, rtData, wbData, wbWrite, wbAddress,
        input  prevWrite, prevAddress, prevData, retireCount
    );

    modport slave (
        input  writeRegIn, regAddressIn, readOutSelect, aluOutData, readOutData,
        input  rsAddr, rtAddr,
        output rsData, rtData, wbData, wbWrite, wbAddress,
        output prevWrite, prevAddress, prevData, retireCount
    );
endinterface
`default_nettype wire

// File: rtl/simple_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : simple_regfile
//  Description : 2-read / 1-write register array with synchronous clear.
//                P5_WRITE_THROUGH_EN bypasses the write port onto the reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module simple_regfile
    import simple_pkg::*;
#(
    parameter int DATA_W = SIMPLE_DATA_W,
    parameter int ADDR_W = SIMPLE_REG_ADDR_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic [ADDR_W-1:0] i_raddr_a,
    input  wire logic [ADDR_W-1:0] i_raddr_b,
    output      logic [DATA_W-1:0] o_rdata_a,
    output      logic [DATA_W-1:0] o_rdata_b
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] w_arr_a;
    logic [DATA_W-1:0] w_arr_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign w_arr_a = r_regs[i_raddr_a];
    assign w_arr_b = r_regs[i_raddr_b];

`ifdef P5_WRITE_THROUGH_EN
    // i_we is already forced low during reset, so no bypass leaks then
    assign o_rdata_a = (i_we && (i_raddr_a == i_waddr)) ? i_wdata : w_arr_a;
    assign o_rdata_b = (i_we && (i_raddr_b == i_waddr)) ? i_wdata : w_arr_b;
`else
    assign o_rdata_a = w_arr_a;
    assign o_rdata_b = w_arr_b;
`endif

endmodule
`default_nettype wire

// File: rtl/p5_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : p5_writeback
//  Description : Writeback stage: result select, register commit, retired
//                write counter and previous-write forwarding registers.
//                Optional macro: P5_WRITE_THROUGH_EN (register file bypass).
//  Revision    : 1.0 - initial release
// ============================================================================
module p5_writeback
    import simple_pkg::*;
#(
    parameter int DATA_W = SIMPLE_DATA_W,
    parameter int ADDR_W = SIMPLE_REG_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  wire logic       clock,
    input  wire logic       reset,
    p5_writeback_if.slave   bus
);

    logic [DATA_W-1:0] w_wb_data;
    logic              w_wb_write;
    logic [CNT_W-1:0]  r_retire_count;
    logic              r_prev_write;
    logic [ADDR_W-1:0] r_prev_address;
    logic [DATA_W-1:0] r_prev_data;

    assign w_wb_data  = bus.readOutSelect ? bus.readOutData : bus.aluOutData;
    assign w_wb_write = bus.writeRegIn & ~reset;

    simple_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk       (clock),
        .rst       (reset),
        .i_we      (w_wb_write),
        .i_waddr   (bus.regAddressIn),
        .i_wdata   (w_wb_data),
        .i_raddr_a (bus.rsAddr),
        .i_raddr_b (bus.rtAddr),
        .o_rdata_a (bus.rsData),
        .o_rdata_b (bus.rtData)
    );

    // Forwarding registers track the stage every cycle, write or not
    always_ff @(posedge clock) begin
        if (reset) begin
            r_retire_count <= '0;
            r_prev_write   <= 1'b0;
            r_prev_address <= '0;
            r_prev_data    <= '0;
        end else begin
            if (bus.writeRegIn) begin
                r_retire_count <= r_retire_count + 1'b1;
            end
            r_prev_write   <= bus.writeRegIn;
            r_prev_address <= bus.regAddressIn;
            r_prev_data    <= w_wb_data;
        end
    end

    assign bus.wbData      = w_wb_data;
    assign bus.wbWrite     = w_wb_write;
    assign bus.wbAddress   = bus.regAddressIn;
    assign bus.prevWrite   = r_prev_write;
    assign bus.prevAddress = r_prev_address;
    assign bus.prevData    = r_prev_data;
    assign bus.retireCount = r_retire_count;

endmodule
`default_nettype wire
